// File: rtl/gene_network_stepper_pkg.sv
// Shared definitions for the gene network stepper: default sizing and the
// sweep controller state encoding.
package gene_network_stepper_pkg;

    localparam int DEF_N         = 8;
    localparam int DEF_MAX_STEPS = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        NEXT = 2'd3
    } state_t;

endpackage

// File: rtl/gene_update_rule.sv
// Combinational threshold update of an N-gene Boolean network: a gene turns on
// when its active activators are at least as many as its active inhibitors.
module gene_update_rule #(
    parameter int               N   = 8,
    parameter logic [N*N-1:0]   ACT = '0,
    parameter logic [N*N-1:0]   INH = '0
) (
    input  logic [N-1:0] x,
    output logic [N-1:0] x_next
);

    localparam int CW = $clog2(N + 1);

    function automatic logic [CW-1:0] popcount(input logic [N-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int b = 0; b < N; b++) begin
            c = c + CW'(v[b]);
        end
        return c;
    endfunction

    always_comb begin
        x_next = '0;
        for (int i = 0; i < N; i++) begin
            x_next[i] = popcount(x & ACT[i*N +: N]) >= popcount(x & INH[i*N +: N]);
        end
    end

endmodule

// File: rtl/gene_network_stepper.sv
// Sweeps every initial state of a threshold Boolean network, stepping it once
// per clock until the external checker flags a fixed point or the step budget runs out.
module gene_network_stepper
    import gene_network_stepper_pkg::*;
#(
    parameter int               N         = DEF_N,
    parameter int               MAX_STEPS = DEF_MAX_STEPS,
    parameter logic [N*N-1:0]   ACT       = '0,
    parameter logic [N*N-1:0]   INH       = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          flag_in,
    output logic [N-1:0]                  x,
    output logic [N-1:0]                  init_out,
    output logic                          busy,
    output logic                          fp_valid,
    output logic [N-1:0]                  fp_init,
    output logic [N-1:0]                  fp_state,
    output logic [$clog2(MAX_STEPS)-1:0]  fp_steps,
    output logic                          timeout,
    output logic [N:0]                    fp_count,
    output logic                          done
);

    localparam int SW = $clog2(MAX_STEPS);

    state_t         state;
    state_t         state_next;
    logic [SW-1:0]  step_cnt;
    logic [N-1:0]   x_next;
    logic           fp_hit;
    logic           to_hit;
    logic           last_init;

    gene_update_rule #(
        .N   (N),
        .ACT (ACT),
        .INH (INH)
    ) u_rule (
        .x      (x),
        .x_next (x_next)
    );

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        fp_hit     = 1'b0;
        to_hit     = 1'b0;
        last_init  = (init_out == '1);
        case (state)
            IDLE: if (start) state_next = LOAD;
            LOAD: state_next = RUN;
            RUN: begin
                // The checker's flag is one edge late and may still describe the
                // previous trajectory during the first two steps.
                fp_hit = flag_in && (step_cnt >= SW'(2));
                to_hit = !fp_hit && (step_cnt == SW'(MAX_STEPS - 1));
                if (fp_hit || to_hit) state_next = NEXT;
            end
            NEXT: state_next = last_init ? IDLE : LOAD;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x        <= '0;
            init_out <= '0;
            step_cnt <= '0;
            fp_valid <= 1'b0;
            fp_init  <= '0;
            fp_state <= '0;
            fp_steps <= '0;
            timeout  <= 1'b0;
            fp_count <= '0;
            done     <= 1'b0;
        end else begin
            fp_valid <= 1'b0;
            timeout  <= 1'b0;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        init_out <= '0;
                        fp_count <= '0;
                    end
                end
                LOAD: begin
                    x        <= init_out;
                    step_cnt <= '0;
                end
                RUN: begin
                    if (fp_hit) begin
                        fp_valid <= 1'b1;
                        fp_init  <= init_out;
                        fp_state <= x;
                        fp_steps <= step_cnt;
                        fp_count <= fp_count + (N+1)'(1);
                    end else if (to_hit) begin
                        timeout  <= 1'b1;
                        fp_init  <= init_out;
                        fp_steps <= step_cnt;
                    end else begin
                        x        <= x_next;
                        step_cnt <= step_cnt + SW'(1);
                    end
                end
                NEXT: begin
                    if (last_init) begin
                        done <= 1'b1;
                    end else begin
                        init_out <= init_out + N'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gene_network_stepper.sv
// Self-checking bench: three 3-gene networks (constitutive, repressilator,
// self-inhibition) swept in parallel, each paired with a fixed-point checker model.
module tb_gene_network_stepper;

    typedef struct packed {
        logic       is_fp;
        logic       is_to;
        logic [2:0] init;
        logic [2:0] state;
        logic [2:0] steps;
    } ev_t;

    localparam logic [8:0] INH_REP  = 9'b010_001_100;
    localparam logic [8:0] INH_SELF = 9'b100_010_001;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] force_flag;
    logic       clr_log;
    logic [2:0] busy_v;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam logic [8:0] INH_P = (g == 0) ? 9'd0 : (g == 1) ? INH_REP : INH_SELF;

        logic [2:0] x, init_out, fp_init, fp_state, fp_steps, chk_prev;
        logic [3:0] fp_count, cnt_at_done;
        logic       busy, fp_valid, timeout, done, flag_in, chk_flag;
        ev_t        ev_log [16];
        int         ev_n;
        int         done_n;

        assign flag_in   = chk_flag | force_flag[g];
        assign busy_v[g] = busy;

        gene_network_stepper #(
            .N         (3),
            .MAX_STEPS (8),
            .ACT       (9'd0),
            .INH       (INH_P)
        ) dut (
            .clk      (clk),
            .rst      (rst),
            .start    (start),
            .flag_in  (flag_in),
            .x        (x),
            .init_out (init_out),
            .busy     (busy),
            .fp_valid (fp_valid),
            .fp_init  (fp_init),
            .fp_state (fp_state),
            .fp_steps (fp_steps),
            .timeout  (timeout),
            .fp_count (fp_count),
            .done     (done)
        );

        // Fixed-point checker: flags, one edge late, that x did not change.
        always @(posedge clk or negedge rst) begin
            if (!rst) begin
                chk_prev <= '0;
                chk_flag <= 1'b0;
            end else begin
                chk_prev <= x;
                chk_flag <= (x == chk_prev);
            end
        end

        always @(negedge clk) begin
            if (clr_log) begin
                ev_n        <= 0;
                done_n      <= 0;
                cnt_at_done <= '0;
            end else if (rst) begin
                if ((fp_valid || timeout) && ev_n < 16) begin
                    ev_log[ev_n] <= '{fp_valid, timeout, fp_init,
                                      fp_valid ? fp_state : 3'd0, fp_steps};
                    ev_n <= ev_n + 1;
                end
                if (done) begin
                    done_n      <= done_n + 1;
                    cnt_at_done <= fp_count;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [2:0] rule(input logic [2:0] xv, input logic [8:0] act,
                                        input logic [8:0] inh);
        logic [2:0] nx;
        nx = '0;
        for (int i = 0; i < 3; i++) begin
            int na = 0;
            int ni = 0;
            for (int b = 0; b < 3; b++) begin
                na += int'(act[i*3+b] & xv[b]);
                ni += int'(inh[i*3+b] & xv[b]);
            end
            nx[i] = (na >= ni);
        end
        return nx;
    endfunction

    // Trajectory x_s at step s; the checker reports at step s when x_{s-1}==x_{s-2}.
    function automatic ev_t predict(input logic [2:0] init, input logic [8:0] act,
                                    input logic [8:0] inh, input int force_step);
        logic [2:0] xs [9];
        xs[0] = init;
        for (int s = 0; s < 8; s++) xs[s+1] = rule(xs[s], act, inh);
        for (int s = 2; s <= 7; s++) begin
            if (xs[s-1] == xs[s-2] || s == force_step)
                return '{1'b1, 1'b0, init, xs[s], 3'(s)};
        end
        return '{1'b0, 1'b1, init, 3'd0, 3'd7};
    endfunction

    task automatic check_inst(input int idx, input ev_t log_in [16], input int n,
                              input int dn, input logic [3:0] cnt,
                              input logic [8:0] inh, input int force_step0);
        ev_t exp_ev;
        int  exp_cnt = 0;
        check($sformatf("inst%0d event_count", idx), 32'(n), 32'd8);
        for (int i = 0; i < 8; i++) begin
            exp_ev = predict(3'(i), 9'd0, inh, (i == 0) ? force_step0 : -1);
            if (exp_ev.is_fp) exp_cnt++;
            check($sformatf("inst%0d event init%0d", idx, i), 32'(log_in[i]), 32'(exp_ev));
        end
        check($sformatf("inst%0d done_pulses", idx), 32'(dn), 32'd1);
        check($sformatf("inst%0d fp_count", idx), 32'(cnt), 32'(exp_cnt));
    endtask

    task automatic wait_idle(input bit spurious);
        int k = 0;
        while (busy_v != 3'b000 && k < 400) begin
            start = spurious && (busy_v == 3'b111) && ($urandom_range(0, 6) == 0);
            tick();
            k++;
        end
        start = 1'b0;
        check("sweep_finishes", 32'(busy_v), 32'd0);
        repeat (3) tick();
    endtask

    task automatic begin_sweep();
        clr_log = 1'b1;
        tick();
        clr_log = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k;
        rst        = 1'b0;
        start      = 1'b0;
        force_flag = 3'b000;
        clr_log    = 1'b1;
        repeat (3) tick();
        check("reset busy", 32'(busy_v), 32'd0);
        check("reset x", 32'(g_inst[0].x), 32'd0);
        check("reset fp_count", 32'(g_inst[0].fp_count), 32'd0);
        check("reset init_out", 32'(g_inst[1].init_out), 32'd0);
        rst = 1'b1;
        tick();

        // Random flag activity while idle must not start or report anything.
        repeat ($urandom_range(2, 6)) begin
            force_flag = 3'($urandom);
            tick();
        end
        force_flag = 3'b000;
        check("idle busy after flags", 32'(busy_v), 32'd0);

        // Full sweeps with random spurious start pulses while busy.
        begin_sweep();
        wait_idle(1'b1);
        check_inst(0, g_inst[0].ev_log, g_inst[0].ev_n, g_inst[0].done_n, g_inst[0].cnt_at_done, 9'd0, -1);
        check_inst(1, g_inst[1].ev_log, g_inst[1].ev_n, g_inst[1].done_n, g_inst[1].cnt_at_done, INH_REP, -1);
        check_inst(2, g_inst[2].ev_log, g_inst[2].ev_n, g_inst[2].done_n, g_inst[2].cnt_at_done, INH_SELF, -1);

        // Flag forced on the timeout edge of init 0 in the repressilator.
        begin_sweep();
        repeat (8) tick();
        force_flag = 3'b010;
        tick();
        force_flag = 3'b000;
        wait_idle(1'b0);
        check_inst(1, g_inst[1].ev_log, g_inst[1].ev_n, g_inst[1].done_n, g_inst[1].cnt_at_done, INH_REP, 7);
        check_inst(0, g_inst[0].ev_log, g_inst[0].ev_n, g_inst[0].done_n, g_inst[0].cnt_at_done, 9'd0, -1);

        // Asynchronous reset while the repressilator runs init 3.
        begin_sweep();
        k = 0;
        while (g_inst[1].init_out != 3'd3 && k < 200) begin
            tick();
            k++;
        end
        check("reach init3", 32'(g_inst[1].init_out), 32'd3);
        tick();
        tick();
        check("busy before reset", 32'(busy_v[1]), 32'd1);
        rst = 1'b0;
        #1;
        check("async x", 32'(g_inst[1].x), 32'd0);
        check("async init_out", 32'(g_inst[1].init_out), 32'd0);
        check("async busy", 32'(busy_v), 32'd0);
        check("async fp_count", 32'(g_inst[0].fp_count), 32'd0);
        check("async fp_regs", 32'({g_inst[1].fp_init, g_inst[1].fp_state, g_inst[1].fp_steps}), 32'd0);
        check("async pulses", 32'({g_inst[1].fp_valid, g_inst[1].timeout, g_inst[1].done}), 32'd0);
        clr_log = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        clr_log = 1'b0;
        repeat (5) tick();
        check("post reset idle", 32'(busy_v), 32'd0);
        check("post reset no events", 32'(g_inst[1].ev_n + g_inst[1].done_n), 32'd0);

        begin_sweep();
        wait_idle(1'b0);
        check_inst(0, g_inst[0].ev_log, g_inst[0].ev_n, g_inst[0].done_n, g_inst[0].cnt_at_done, 9'd0, -1);
        check_inst(1, g_inst[1].ev_log, g_inst[1].ev_n, g_inst[1].done_n, g_inst[1].cnt_at_done, INH_REP, -1);
        check_inst(2, g_inst[2].ev_log, g_inst[2].ev_n, g_inst[2].done_n, g_inst[2].cnt_at_done, INH_SELF, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
